brew_sequencer: RTL and testbench



---
 rtl/brew_sequencer.sv | 163 ++++++++++++++++
 tb/tb_brew_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/brew_sequencer.sv
// Brew phase sequencer: steps heater, grinder, pump and milk valve through fixed-length
// phases for one drink order, with sensor-fault and user-cancel aborts.
module brew_sequencer #(
    parameter int CNT_W      = 8,
    parameter int HEAT_CYC   = 8,
    parameter int GRIND_CYC  = 4,
    parameter int BREW_SHORT = 6,
    parameter int BREW_LONG  = 12,
    parameter int MILK_CYC   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] drink,
    input  logic       cup_ok,
    input  logic       water_ok,
    input  logic       cancel,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       heater_on,
    output logic       grinder_on,
    output logic       pump_on,
    output logic       milk_on,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HEAT  = 3'd1,
        GRIND = 3'd2,
        BREW  = 3'd3,
        MILK  = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] HEAT_LOAD  = CNT_W'(HEAT_CYC - 1);
    localparam logic [CNT_W-1:0] GRIND_LOAD = CNT_W'(GRIND_CYC - 1);
    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(BREW_SHORT - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(BREW_LONG - 1);
    localparam logic [CNT_W-1:0] MILK_LOAD  = CNT_W'(MILK_CYC - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       drink_r;
    logic [1:0]       drink_nxt_s;
    logic [6:0]       outs_r;
    logic             fault_s;

    // Output bit order: busy, done, error, heater, grinder, pump, milk
    function automatic logic [6:0] decode_outs(input state_t st);
        logic [6:0] o;
        case (st)
            HEAT:    o = 7'b100_1000;
            GRIND:   o = 7'b100_0100;
            BREW:    o = 7'b100_0010;
            MILK:    o = 7'b100_0001;
            DONE:    o = 7'b010_0000;
            ERROR:   o = 7'b001_0000;
            default: o = 7'b000_0000;
        endcase
        return o;
    endfunction

    assign fault_s = (cup_ok == 1'b0) || (water_ok == 1'b0);

    // Next-state, phase counter and drink latch
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        drink_nxt_s = drink_r;
        case (state_r)
            IDLE: begin
                if (start && (drink != 2'd0)) begin
                    drink_nxt_s = drink;
                    if (fault_s) begin
                        state_nxt_s = ERROR;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = HEAT;
                        cnt_nxt_s   = HEAT_LOAD;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HEAT, GRIND, BREW, MILK: begin
                // Fault beats cancel, and both beat phase completion
                if (fault_s) begin
                    state_nxt_s = ERROR;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cancel) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_ZERO) begin
                    case (state_r)
                        HEAT: begin
                            state_nxt_s = GRIND;
                            cnt_nxt_s   = GRIND_LOAD;
                        end
                        GRIND: begin
                            state_nxt_s = BREW;
                            cnt_nxt_s   = (drink_r == 2'd2) ? LONG_LOAD : SHORT_LOAD;
                        end
                        BREW: begin
                            if (drink_r == 2'd3) begin
                                state_nxt_s = MILK;
                                cnt_nxt_s   = MILK_LOAD;
                            end else begin
                                state_nxt_s = DONE;
                                cnt_nxt_s   = CNT_ZERO;
                            end
                        end
                        default: begin
                            state_nxt_s = DONE;
                            cnt_nxt_s   = CNT_ZERO;
                        end
                    endcase
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            ERROR: begin
                if (cancel) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ERROR;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State registers; outputs are decoded from the next state so they line up with state_r
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            drink_r <= 2'd0;
            outs_r  <= 7'b000_0000;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            drink_r <= drink_nxt_s;
            outs_r  <= decode_outs(state_nxt_s);
        end
    end

    assign {busy, done, error, heater_on, grinder_on, pump_on, milk_on} = outs_r;
    assign state = state_r;

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed bench for brew_sequencer: walks each drink through its phases and exercises
// fault, cancel, back-to-back and asynchronous reset behaviour.
module tb_brew_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] drink;
    logic       cup_ok;
    logic       water_ok;
    logic       cancel;
    logic       busy;
    logic       done;
    logic       error;
    logic       heater_on;
    logic       grinder_on;
    logic       pump_on;
    logic       milk_on;
    logic [2:0] state;

    int checks;
    int failures;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HEAT  = 3'd1;
    localparam logic [2:0] S_GRIND = 3'd2;
    localparam logic [2:0] S_BREW  = 3'd3;
    localparam logic [2:0] S_MILK  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    brew_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .drink      (drink),
        .cup_ok     (cup_ok),
        .water_ok   (water_ok),
        .cancel     (cancel),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .heater_on  (heater_on),
        .grinder_on (grinder_on),
        .pump_on    (pump_on),
        .milk_on    (milk_on),
        .state      (state)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {busy, done, error, heater, grinder, pump, milk, state} for a state code
    function automatic logic [9:0] expect_outs(input logic [2:0] st);
        logic [6:0] o;
        case (st)
            S_HEAT:  o = 7'b100_1000;
            S_GRIND: o = 7'b100_0100;
            S_BREW:  o = 7'b100_0010;
            S_MILK:  o = 7'b100_0001;
            S_DONE:  o = 7'b010_0000;
            S_ERROR: o = 7'b001_0000;
            default: o = 7'b000_0000;
        endcase
        return {o, st};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st);
        logic [9:0] obs;
        logic [9:0] exp_v;
        obs   = {busy, done, error, heater_on, grinder_on, pump_on, milk_on, state};
        exp_v = expect_outs(st);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic run_phase(input string tag, input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) begin
            check_outs(tag, st);
            step();
        end
    endtask

    task automatic order(input logic [1:0] d);
        drink = d;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        drink    = 2'd0;
        cup_ok   = 1'b1;
        water_ok = 1'b1;
        cancel   = 1'b0;
        #1;
        check_outs("reset_state", S_IDLE);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_outs("idle_after_reset", S_IDLE);

        // Espresso, then a start held through DONE
        order(2'd1);
        run_phase("esp_heat", S_HEAT, 8);
        run_phase("esp_grind", S_GRIND, 4);
        run_phase("esp_brew", S_BREW, 6);
        check_outs("esp_done", S_DONE);
        start = 1'b1;
        drink = 2'd1;
        step();
        check_outs("b2b_ignored_in_done", S_IDLE);
        step();
        start = 1'b0;
        check_outs("b2b_accepted", S_HEAT);

        // Cancel in GRIND cycle 2
        step();
        run_phase("cxl_heat", S_HEAT, 7);
        run_phase("cxl_grind", S_GRIND, 1);
        check_outs("cxl_grind2", S_GRIND);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        run_phase("cxl_idle_no_done", S_IDLE, 3);

        // Long coffee
        order(2'd2);
        run_phase("long_heat", S_HEAT, 8);
        run_phase("long_grind", S_GRIND, 4);
        run_phase("long_brew", S_BREW, 12);
        run_phase("long_done", S_DONE, 1);
        check_outs("long_idle", S_IDLE);

        // Coffee with milk
        order(2'd3);
        run_phase("milk_heat", S_HEAT, 8);
        run_phase("milk_grind", S_GRIND, 4);
        run_phase("milk_brew", S_BREW, 6);
        run_phase("milk_milk", S_MILK, 5);
        run_phase("milk_done", S_DONE, 1);
        check_outs("milk_idle", S_IDLE);

        // Missing cup at start, sticky error, cancel clears
        cup_ok = 1'b0;
        order(2'd1);
        check_outs("nocup_error", S_ERROR);
        cup_ok = 1'b1;
        step();
        check_outs("error_sticky", S_ERROR);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check_outs("error_cleared", S_IDLE);

        // Water fault together with cancel in BREW cycle 3
        order(2'd1);
        run_phase("flt_heat", S_HEAT, 8);
        run_phase("flt_grind", S_GRIND, 4);
        run_phase("flt_brew", S_BREW, 2);
        check_outs("flt_brew3", S_BREW);
        water_ok = 1'b0;
        cancel   = 1'b1;
        step();
        water_ok = 1'b1;
        cancel   = 1'b0;
        check_outs("flt_fault_wins", S_ERROR);
        step();
        check_outs("flt_error_hold", S_ERROR);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check_outs("flt_cleared", S_IDLE);

        // Asynchronous reset between edges in HEAT
        order(2'd1);
        run_phase("rst_heat", S_HEAT, 3);
        check_outs("rst_heat4", S_HEAT);
        #3;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset_immediate", S_IDLE);
        #2;
        rst_n = 1'b1;
        drink = 2'd0;
        start = 1'b1;
        step();
        check_outs("drink0_ignored", S_IDLE);
        step();
        start = 1'b0;
        check_outs("drink0_still_idle", S_IDLE);

        // Fresh order after reset has full-length HEAT
        order(2'd1);
        run_phase("post_rst_heat", S_HEAT, 8);
        check_outs("post_rst_grind", S_GRIND);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
